unconfig_int_sub_pipe: RTL and testbench



---
 rtl/unconfig_int_sub_pipe.sv | 116 +++++++++++
 tb/tb_unconfig_int_sub_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/unconfig_int_sub_pipe.sv
// Two-stage valid/ready truncating unsigned subtractor on the top OP_BITWIDTH bits.
// Optional macro SUB_SATURATE_EN clamps an underflowed difference to zero instead of wrapping.
module unconfig_int_sub_pipe #(
    parameter int unsigned OP_BITWIDTH        = 16,
    parameter int unsigned DATA_PATH_BITWIDTH = 16,
    parameter int unsigned CNT_W              = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_PATH_BITWIDTH-1:0] a,
    input  logic [DATA_PATH_BITWIDTH-1:0] b,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_PATH_BITWIDTH-1:0] c,
    output logic                          borrow,
    output logic                          out_valid,
    input  logic                          out_ready,
    input  logic                          cnt_clr,
    output logic [CNT_W-1:0]              uf_cnt
);

    localparam int unsigned LOW_W = DATA_PATH_BITWIDTH - OP_BITWIDTH;

    logic [OP_BITWIDTH-1:0]        a_q, a_d, b_q, b_d;
    logic                          s1_valid_q, s1_valid_d;
    logic [DATA_PATH_BITWIDTH-1:0] c_q, c_d;
    logic                          borrow_q, borrow_d;
    logic                          out_valid_q, out_valid_d;
    logic [CNT_W-1:0]              uf_cnt_q, uf_cnt_d;

    logic                          s2_load_c;
    logic                          accept_c;
    logic                          xfer_c;
    logic [OP_BITWIDTH:0]          diff_ext_c;
    logic [OP_BITWIDTH-1:0]        res_top_c;
    logic                          unused_low_c;

    // Low operand bits are ignored by the operator.
    assign unused_low_c = ^{a, b};

    assign s2_load_c = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready  = !s1_valid_q || s2_load_c;
    assign accept_c  = in_valid && in_ready;
    assign xfer_c    = out_valid_q && out_ready;

    // Extra MSB of the widened subtraction is the borrow.
    assign diff_ext_c = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        res_top_c = diff_ext_c[OP_BITWIDTH-1:0];
`ifdef SUB_SATURATE_EN
        if (diff_ext_c[OP_BITWIDTH]) begin
            res_top_c = '0;
        end
`endif
    end

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        s1_valid_d  = s1_valid_q;
        c_d         = c_q;
        borrow_d    = borrow_q;
        out_valid_d = out_valid_q;
        uf_cnt_d    = uf_cnt_q;

        if (accept_c) begin
            a_d        = a[DATA_PATH_BITWIDTH-1 -: OP_BITWIDTH];
            b_d        = b[DATA_PATH_BITWIDTH-1 -: OP_BITWIDTH];
            s1_valid_d = 1'b1;
        end else if (s2_load_c) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load_c) begin
            c_d         = DATA_PATH_BITWIDTH'(res_top_c) << LOW_W;
            borrow_d    = diff_ext_c[OP_BITWIDTH];
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Clear wins over a same-cycle increment; count saturates at all-ones.
        if (cnt_clr) begin
            uf_cnt_d = '0;
        end else if (xfer_c && borrow_q && (uf_cnt_q != {CNT_W{1'b1}})) begin
            uf_cnt_d = uf_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q         <= '0;
            b_q         <= '0;
            s1_valid_q  <= 1'b0;
            c_q         <= '0;
            borrow_q    <= 1'b0;
            out_valid_q <= 1'b0;
            uf_cnt_q    <= '0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            s1_valid_q  <= s1_valid_d;
            c_q         <= c_d;
            borrow_q    <= borrow_d;
            out_valid_q <= out_valid_d;
            uf_cnt_q    <= uf_cnt_d;
        end
    end

    assign c         = c_q;
    assign borrow    = borrow_q;
    assign out_valid = out_valid_q;
    assign uf_cnt    = uf_cnt_q;

endmodule

// File: tb/tb_unconfig_int_sub_pipe.sv
// Scoreboard bench for unconfig_int_sub_pipe (OP=8, DP=16, CNT_W=2); honours SUB_SATURATE_EN.
module tb_unconfig_int_sub_pipe;

    localparam int unsigned OPW  = 8;
    localparam int unsigned DPW  = 16;
    localparam int unsigned CW   = 2;
    localparam int unsigned LOW  = DPW - OPW;
    localparam int          CMAX = (1 << CW) - 1;

    typedef struct {
        logic [DPW-1:0] c;
        logic           b;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [DPW-1:0] a, b;
    logic           in_valid, in_ready;
    logic [DPW-1:0] c;
    logic           borrow, out_valid, out_ready, cnt_clr;
    logic [CW-1:0]  uf_cnt;

    int checks   = 0;
    int failures = 0;
    int npop     = 0;
    int exp_cnt  = 0;
    exp_t q[$];

    unconfig_int_sub_pipe #(
        .OP_BITWIDTH(OPW), .DATA_PATH_BITWIDTH(DPW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
        .c(c), .borrow(borrow), .out_valid(out_valid), .out_ready(out_ready),
        .cnt_clr(cnt_clr), .uf_cnt(uf_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand top fields.
    function automatic exp_t model(input logic [DPW-1:0] av, input logic [DPW-1:0] bv);
        exp_t r;
        int at, bt, d;
        at = int'(av >> LOW);
        bt = int'(bv >> LOW);
        r.b = (at < bt);
        d = (at >= bt) ? (at - bt) : (at - bt + (1 << OPW));
`ifdef SUB_SATURATE_EN
        if (r.b) d = 0;
`endif
        r.c = DPW'(d << LOW);
        return r;
    endfunction

    // Monitor: accepts push expectations, presented results are compared, transfers pop.
    always @(negedge clk) begin
        logic xfer, nb;
        if (!rst) begin
            q.delete();
            exp_cnt = 0;
        end else begin
            chk("uf_cnt", 32'(uf_cnt), 32'(exp_cnt));
            xfer = out_valid && out_ready;
            nb = 1'b0;
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 32'(1), 32'(0));
                end else begin
                    chk("c", 32'(c), 32'(q[0].c));
                    chk("borrow", 32'(borrow), 32'(q[0].b));
                end
            end
            if (xfer && q.size() > 0) begin
                nb = q[0].b;
                void'(q.pop_front());
                npop++;
            end
            if (in_valid && in_ready) q.push_back(model(a, b));
            if (cnt_clr) exp_cnt = 0;
            else if (xfer && nb && exp_cnt < CMAX) exp_cnt++;
        end
    end

    task automatic send(input logic [DPW-1:0] av, input logic [DPW-1:0] bv);
        bit ok;
        @(posedge clk); #1;
        a = av; b = bv; in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("send_timeout", 32'(0), 32'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int quiet;
        quiet = 0;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 40 && quiet < 3; i++) begin
            @(negedge clk);
            if (!out_valid) quiet++; else quiet = 0;
        end
        #1;
        chk("drain_queue_empty", 32'(q.size()), 32'(0));
    endtask

    initial begin
        logic [DPW-1:0] pa[4];
        logic [DPW-1:0] pb[4];
        int idx, pop0;

        rst = 1'b0; in_valid = 1'b1; a = 16'h1234; b = 16'h0101;
        out_ready = 1'b1; cnt_clr = 1'b0;

        // Reset held with in_valid asserted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_out_valid", 32'(out_valid), 32'(0));
            chk("rst_c", 32'(c), 32'(0));
            chk("rst_uf_cnt", 32'(uf_cnt), 32'(0));
        end
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(in_ready), 32'(1));

        // Basic: two-cycle latency, one-cycle valid pulse.
        send(16'h5A12, 16'h2034);
        @(negedge clk); chk("basic_lat_cyc1", 32'(out_valid), 32'(0));
        @(negedge clk); chk("basic_lat_cyc2", 32'(out_valid), 32'(1));
        chk("basic_c", 32'(c), 32'(16'h3A00));
        chk("basic_borrow", 32'(borrow), 32'(0));
        @(negedge clk); chk("basic_pulse", 32'(out_valid), 32'(0));

        // Underflow.
        send(16'h1000, 16'h3000);
        @(negedge clk);
        @(negedge clk);
        chk("uf_borrow", 32'(borrow), 32'(1));
`ifdef SUB_SATURATE_EN
        chk("uf_c", 32'(c), 32'(16'h0000));
`else
        chk("uf_c", 32'(c), 32'(16'hE000));
`endif
        @(negedge clk); chk("uf_cnt_one", 32'(uf_cnt), 32'(1));

        // Equal operands.
        send(16'h7777, 16'h77FF);
        drain();

        // Backpressure: 4 pairs, sink stalled for 5 cycles.
        pa = '{16'h9000, 16'h2000, 16'hFF00, 16'h4400};
        pb = '{16'h1000, 16'h8000, 16'h0100, 16'h4400};
        pop0 = npop;
        idx = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(posedge clk); #1;
            out_ready = (cyc >= 5);
            if (idx < 4) begin a = pa[idx]; b = pb[idx]; end
            in_valid = (idx < 4);
            @(negedge clk);
            if (cyc == 2 || cyc == 4) chk("bp_in_ready_low", 32'(in_ready), 32'(0));
            if (in_valid && in_ready) idx++;
        end
        drain();
        chk("bp_accepted", 32'(idx), 32'(4));
        chk("bp_delivered", 32'(npop - pop0), 32'(4));

        // Counter saturation, then clear colliding with an underflow transfer.
        @(posedge clk); #1; cnt_clr = 1'b1;
        @(posedge clk); #1; cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) send(16'h0100 * (i + 1), 16'hF000);
        drain();
        chk("cnt_saturated", 32'(uf_cnt), 32'(CMAX));
        @(posedge clk); #1; out_ready = 1'b0;
        send(16'h0000, 16'h0100);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        @(posedge clk); #1; cnt_clr = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1; cnt_clr = 1'b0;
        @(negedge clk); chk("cnt_clr_priority", 32'(uf_cnt), 32'(0));
        drain();

        // Mid-operation reset drops in-flight data.
        @(posedge clk); #1; out_ready = 1'b0;
        send(16'h8000, 16'h0100);
        send(16'h0100, 16'h8000);
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1; rst = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("midrst_no_valid", 32'(out_valid), 32'(0));
        end
        send(16'hC300, 16'h4100);
        @(negedge clk); chk("midrst_lat_cyc1", 32'(out_valid), 32'(0));
        @(negedge clk); chk("midrst_lat_cyc2", 32'(out_valid), 32'(1));
        chk("midrst_c", 32'(c), 32'(16'h8200));
        drain();

        // Random traffic with random backpressure and occasional clears.
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            a = 16'($urandom); b = 16'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            cnt_clr   = ($urandom_range(0, 31) == 0);
        end
        @(posedge clk); #1; cnt_clr = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
